gamma_cycle_ctrl: RTL and testbench

- Sequencer for the race-logic (space-time) temporal operators, e.g. the less-than-or-equal cell.
- Divides time into gamma cycles and clears the operators' SR latches before each cycle.
- Converts latched binary input times into rising edges, then timestamps the operator's output edge.
- Sits between a binary-valued host (start/done handshake) and a combinational temporal datapath.

---
 rtl/gamma_cycle_ctrl.sv | 112 +++++++++++
 tb/tb_gamma_cycle_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gamma_cycle_ctrl.sv
// gamma_cycle_ctrl: gamma-cycle sequencer for race-logic temporal operators (IDLE/CLEAR/RUN/REPORT).
// Optional GAMMA_FREE_RUN_EN: back-to-back gamma cycles after the first accept.
module gamma_cycle_ctrl #(
  parameter int NUM_IN            = 2,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int TIME_W            = $clog2(GAMMA_CYCLE_WIDTH) + 1,
  parameter int RST_CYCLES        = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       ready,
  input  logic [NUM_IN*TIME_W-1:0]   in_time,
  output logic [NUM_IN-1:0]          edge_out,
  output logic                       grl_rst,
  input  logic                       res_in,
  output logic                       done,
  output logic [TIME_W-1:0]          res_time,
  output logic                       res_fired
);
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, REPORT = 2'd3;
  localparam int CW = $clog2(RST_CYCLES) + 1;
  localparam logic [TIME_W-1:0] LAST = TIME_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TIME_W-1:0] INF  = TIME_W'(GAMMA_CYCLE_WIDTH);
`ifdef GAMMA_FREE_RUN_EN
  localparam bit FREE_RUN = 1'b1;
`else
  localparam bit FREE_RUN = 1'b0;
`endif
  logic [1:0]               state_q, state_d;
  logic [NUM_IN*TIME_W-1:0] t_reg_q, t_reg_d;
  logic [TIME_W-1:0]        tcount_q, tcount_d;
  logic [CW-1:0]            ccount_q, ccount_d;
  logic [TIME_W-1:0]        res_time_q, res_time_d;
  logic                     res_fired_q, res_fired_d;
  logic [NUM_IN-1:0]        edge_out_q, edge_out_d;
  logic                     ready_q, ready_d;
  logic                     grl_rst_q, grl_rst_d;
  logic                     done_q, done_d;
  logic                     load;
  always_comb begin
    state_d     = state_q;
    t_reg_d     = t_reg_q;
    tcount_d    = tcount_q;
    ccount_d    = ccount_q;
    res_time_d  = res_time_q;
    res_fired_d = res_fired_q;
    load        = (state_q == IDLE && start && ready_q) || (state_q == REPORT && FREE_RUN);
    case (state_q)
      CLEAR: begin
        state_d  = (ccount_q == CW'(RST_CYCLES - 1)) ? RUN : CLEAR;
        tcount_d = '0;
        ccount_d = ccount_q + CW'(1);
      end
      RUN: begin
        if (res_in && !res_fired_q) begin
          res_time_d  = tcount_q;
          res_fired_d = 1'b1;
        end
        state_d  = (tcount_q == LAST) ? REPORT : RUN;
        tcount_d = (tcount_q == LAST) ? tcount_q : tcount_q + TIME_W'(1);
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d     = CLEAR;
      t_reg_d     = in_time;
      ccount_d    = '0;
      res_time_d  = INF;
      res_fired_d = 1'b0;
    end
    // Edges are a pure compare against the rising counter, so they can only rise within RUN
    edge_out_d = '0;
    for (int i = 0; i < NUM_IN; i++)
      edge_out_d[i] = (state_d == RUN) && (tcount_d >= t_reg_q[i*TIME_W +: TIME_W]);
    ready_d   = state_d == IDLE;
    grl_rst_d = state_d != RUN;
    done_d    = state_d == REPORT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_reg_q     <= '0;
      tcount_q    <= '0;
      ccount_q    <= '0;
      res_time_q  <= '0;
      res_fired_q <= 1'b0;
      edge_out_q  <= '0;
      ready_q     <= 1'b1;
      grl_rst_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_reg_q     <= t_reg_d;
      tcount_q    <= tcount_d;
      ccount_q    <= ccount_d;
      res_time_q  <= res_time_d;
      res_fired_q <= res_fired_d;
      edge_out_q  <= edge_out_d;
      ready_q     <= ready_d;
      grl_rst_q   <= grl_rst_d;
      done_q      <= done_d;
    end
  end
  assign ready     = ready_q;
  assign edge_out  = edge_out_q;
  assign grl_rst   = grl_rst_q;
  assign done      = done_q;
  assign res_time  = res_time_q;
  assign res_fired = res_fired_q;
endmodule

// File: tb/tb_gamma_cycle_ctrl.sv
// tb_gamma_cycle_ctrl: directed bench for gamma_cycle_ctrl driving a less-than-or-equal race-logic cell.
module tb_gamma_cycle_ctrl;
  localparam int G  = 16;
  localparam int RC = 2;
  localparam int TW = 5;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2*TW-1:0] in_time = '0;
  logic          ready, grl_rst, done, res_fired, res_in;
  logic [1:0]    edge_out;
  logic [TW-1:0] res_time;
  logic          blk_q = 1'b0;
  int            n_chk = 0, n_fail = 0;
  typedef struct {
    logic [TW-1:0] a, b;
    int r0, r1, rt, rf;
  } vec_t;
  vec_t tbl[6];
  gamma_cycle_ctrl #(.NUM_IN(2), .GAMMA_CYCLE_WIDTH(G), .TIME_W(TW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .in_time(in_time),
    .edge_out(edge_out), .grl_rst(grl_rst), .res_in(res_in), .done(done),
    .res_time(res_time), .res_fired(res_fired)
  );
  always #5 clk = ~clk;
  // less_than_eq cell: q follows a unless b arrived strictly earlier
  always @(posedge clk) blk_q <= grl_rst ? 1'b0 : (blk_q | (edge_out[1] & ~edge_out[0]));
  assign res_in = edge_out[0] & ~blk_q;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask
  // j counts clocks with the accept edge as clock 1; RUN cycle k is j = RC+1+k
  task automatic run_gamma(input logic [TW-1:0] a, input logic [TW-1:0] b, output int r0, output int r1,
                           output int dn, output int nrun, output int falls,
                           output logic [TW-1:0] rt, output logic rf);
    r0 = -1; r1 = -1; dn = -1; nrun = 0; falls = 0; rt = '0; rf = 1'b0;
    @(negedge clk);
    in_time = {b, a};
    start = 1'b1;
    chk("ready_before_accept", ready, 1);
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done) begin
        dn = j; rt = res_time; rf = res_fired;
        break;
      end
      if (!grl_rst) nrun++;
      if (edge_out[0] && r0 < 0) r0 = j; else if (!edge_out[0] && r0 >= 0) falls++;
      if (edge_out[1] && r1 < 0) r1 = j; else if (!edge_out[1] && r1 >= 0) falls++;
    end
  endtask
  initial begin
    int r0, r1, dn, nrun, falls, ndone, nrdy;
    int dpos[3];
    logic [TW-1:0] rt;
    logic rf;
    tbl[0] = '{a: 5'd3,  b: 5'd7,  r0: 6,  r1: 10, rt: 3,  rf: 1};
    tbl[1] = '{a: 5'd9,  b: 5'd4,  r0: 12, r1: 7,  rt: 16, rf: 0};
    tbl[2] = '{a: 5'd5,  b: 5'd5,  r0: 8,  r1: 8,  rt: 5,  rf: 1};
    tbl[3] = '{a: 5'd0,  b: 5'd15, r0: 3,  r1: 18, rt: 0,  rf: 1};
    tbl[4] = '{a: 5'd16, b: 5'd2,  r0: -1, r1: 5,  rt: 16, rf: 0};
    tbl[5] = '{a: 5'd31, b: 5'd31, r0: -1, r1: -1, rt: 16, rf: 0};
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_grl_rst", grl_rst, 1);
    chk("rst_edge_out", edge_out, 0);
    chk("rst_done", done, 0);
    chk("rst_res_time", res_time, 0);
    chk("rst_res_fired", res_fired, 0);
`ifdef GAMMA_FREE_RUN_EN
    ndone = 0; nrdy = 0;
    @(negedge clk);
    in_time = {5'd7, 5'd3};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (ready) nrdy++;
      if (done) begin
        if (ndone < 3) dpos[ndone] = j;
        ndone++;
        chk("free_res_time", res_time, 3);
        chk("free_res_fired", res_fired, 1);
      end
    end
    chk("free_done_count", ndone, 3);
    chk("free_first_done", dpos[0], RC + G + 1);
    chk("free_period1", dpos[1] - dpos[0], RC + G + 1);
    chk("free_period2", dpos[2] - dpos[1], RC + G + 1);
    chk("free_ready_low", nrdy, 0);
`else
    for (int v = 0; v < 6; v++) begin
      run_gamma(tbl[v].a, tbl[v].b, r0, r1, dn, nrun, falls, rt, rf);
      chk($sformatf("v%0d_rise_a", v), r0, tbl[v].r0);
      chk($sformatf("v%0d_rise_b", v), r1, tbl[v].r1);
      chk($sformatf("v%0d_done_at", v), dn, RC + G + 1);
      chk($sformatf("v%0d_run_cycles", v), nrun, G);
      chk($sformatf("v%0d_edge_falls", v), falls, 0);
      chk($sformatf("v%0d_res_time", v), rt, tbl[v].rt);
      chk($sformatf("v%0d_res_fired", v), rf, tbl[v].rf);
    end
    // start held high across a whole gamma cycle
    ndone = 0; nrdy = 0; dn = -1;
    @(negedge clk);
    in_time = {5'd7, 5'd3};
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      if (ready) nrdy++;
      if (done) begin ndone++; dn = j; end
    end
    chk("held_done_count", ndone, 1);
    chk("held_done_at", dn, 19);
    chk("held_ready_low", nrdy, 0);
    @(negedge clk);
    chk("held_ready_after_done", ready, 1);
    chk("held_no_done_idle", done, 0);
    @(negedge clk);
    chk("held_reaccept", ready, 0);
    start = 1'b0;
    dn = -1;
    for (int j = 22; j <= 60; j++) begin
      @(negedge clk);
      if (done) begin dn = j; rt = res_time; rf = res_fired; break; end
    end
    chk("held_second_done_at", dn, 39);
    chk("held_second_res_time", rt, 3);
    chk("held_second_res_fired", rf, 1);
    // asynchronous reset in RUN at tcount=6
    @(negedge clk);
    in_time = {5'd7, 5'd3};
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_edge_before_rst", edge_out, 2'b01);
    chk("mid_grl_before_rst", grl_rst, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_grl_rst", grl_rst, 1);
    chk("mid_rst_edge_out", edge_out, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_res_fired", res_fired, 0);
    chk("mid_rst_res_time", res_time, 0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    run_gamma(5'd3, 5'd7, r0, r1, dn, nrun, falls, rt, rf);
    chk("post_rst_done_at", dn, RC + G + 1);
    chk("post_rst_res_time", rt, 3);
    chk("post_rst_res_fired", rf, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
